// File: rtl/serial_add_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : serial_add_ctrl
// Purpose  : Bit-serial adder, one full-adder bit per clock, LSB first.
// Revision : 1.0 - initial release
// ============================================================================
module serial_add_ctrl #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);

    localparam int CW = $clog2(WIDTH + 1);

    localparam logic [1:0] c_IDLE = 2'd0;
    localparam logic [1:0] c_RUN  = 2'd1;
    localparam logic [1:0] c_DONE = 2'd2;

    logic [1:0]       state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic             carry_q, carry_d;
    logic [WIDTH-1:0] res_q, res_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic             cout_q, cout_d;

    logic w_ha1_s, w_ha1_c, w_fa_s, w_ha2_c, w_fa_c, w_last;

    // Single full adder built from two half adders; operand bit i sits at bit 0
    assign w_ha1_s = a_q[0] ^ b_q[0];
    assign w_ha1_c = a_q[0] & b_q[0];
    assign w_fa_s  = w_ha1_s ^ carry_q;
    assign w_ha2_c = w_ha1_s & carry_q;
    assign w_fa_c  = w_ha1_c | w_ha2_c;
    assign w_last  = (cnt_q == CW'(WIDTH - 1));

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        carry_d = carry_q;
        res_d   = res_q;
        cnt_d   = cnt_q;
        sum_d   = sum_q;
        cout_d  = cout_q;
        case (state_q)
            c_IDLE: begin
                if (start) begin
                    a_d     = a;
                    b_d     = b;
                    carry_d = cin;
                    res_d   = '0;
                    cnt_d   = '0;
                    state_d = c_RUN;
                end
            end
            c_RUN: begin
                a_d     = a_q >> 1;
                b_d     = b_q >> 1;
                carry_d = w_fa_c;
                cnt_d   = cnt_q + CW'(1);
                for (int i = 0; i < WIDTH; i++) begin
                    if (cnt_q == CW'(i)) begin
                        res_d[i] = w_fa_s;
                    end
                end
                if (w_last) begin
                    sum_d   = res_d;
                    cout_d  = w_fa_c;
                    state_d = c_DONE;
                end
            end
            c_DONE:  state_d = c_IDLE;
            default: state_d = c_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= c_IDLE;
            a_q     <= '0;
            b_q     <= '0;
            carry_q <= 1'b0;
            res_q   <= '0;
            cnt_q   <= '0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            carry_q <= carry_d;
            res_q   <= res_d;
            cnt_q   <= cnt_d;
            sum_q   <= sum_d;
            cout_q  <= cout_d;
        end
    end

    assign busy = (state_q == c_RUN);
    assign done = (state_q == c_DONE);
    assign sum  = sum_q;
    assign cout = cout_q;

endmodule
`default_nettype wire

// File: tb/tb_serial_add_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_serial_add_ctrl
// Purpose  : Directed and random checks of serial_add_ctrl at WIDTH 8 and 1.
// Revision : 1.0 - initial release
// ============================================================================
module tb_serial_add_ctrl;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       start8, cin8, busy8, done8, cout8;
    logic [7:0] a8, b8, sum8;
    logic       start1, cin1, busy1, done1, cout1;
    logic [0:0] a1, b1, sum1;

    int checks = 0;
    int fails  = 0;

    always #5 clk = ~clk;

    serial_add_ctrl #(.WIDTH(8)) u_dut8 (
        .clk(clk), .rst_n(rst_n), .start(start8), .a(a8), .b(b8), .cin(cin8),
        .busy(busy8), .done(done8), .sum(sum8), .cout(cout8)
    );

    serial_add_ctrl #(.WIDTH(1)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .start(start1), .a(a1), .b(b1), .cin(cin1),
        .busy(busy1), .done(done1), .sum(sum1), .cout(cout1)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // mode: 0 plain, 1 operands zeroed during RUN, 2 extra start in RUN cycle 3,
    // 3 operands randomised during RUN
    task automatic run8(input logic [7:0] ta, input logic [7:0] tb, input logic tc, input int mode);
        logic [8:0] exp;
        int         edges, busyn;
        logic       both;
        exp = 9'(ta) + 9'(tb) + 9'(tc);
        @(negedge clk);
        start8 = 1'b1; a8 = ta; b8 = tb; cin8 = tc;
        @(posedge clk); #1;
        start8 = 1'b0;
        if (mode == 1) begin a8 = 8'h00; b8 = 8'h00; cin8 = 1'b0; end
        if (mode == 3) begin a8 = 8'($urandom); b8 = 8'($urandom); cin8 = 1'($urandom); end
        edges = 0; busyn = 0; both = 1'b0;
        while (!done8 && edges < 20) begin
            if (busy8) busyn++;
            both = both | (busy8 & done8);
            if (mode == 2 && edges == 2) begin start8 = 1'b1; a8 = 8'hF0; end
            else start8 = 1'b0;
            @(posedge clk); #1;
            edges++;
        end
        start8 = 1'b0;
        both = both | (busy8 & done8);
        check("latency8", edges, 8);
        check("busy_cycles8", busyn, 8);
        check("busy_done_excl", {31'd0, both}, 0);
        check("result8", {23'd0, cout8, sum8}, {23'd0, exp});
        @(posedge clk); #1;
        check("done_pulse8", {31'd0, done8}, 0);
        check("hold8", {23'd0, cout8, sum8}, {23'd0, exp});
        if (mode == 2) begin
            for (int i = 0; i < 3; i++) begin
                @(posedge clk); #1;
                check("no_second_op", {30'd0, busy8, done8}, 0);
            end
        end
    endtask

    task automatic run1(input logic ta, input logic tb, input logic tc);
        int edges;
        @(negedge clk);
        start1 = 1'b1; a1 = ta; b1 = tb; cin1 = tc;
        @(posedge clk); #1;
        start1 = 1'b0;
        edges = 0;
        while (!done1 && edges < 10) begin
            @(posedge clk); #1;
            edges++;
        end
        check("latency1", edges, 1);
        check("result1", {30'd0, cout1, sum1}, 32'(ta) + 32'(tb) + 32'(tc));
        @(posedge clk); #1;
    endtask

    initial begin
        rst_n = 1'b0;
        start8 = 1'b1; a8 = 8'h55; b8 = 8'h66; cin8 = 1'b1;
        start1 = 1'b1; a1 = 1'b1; b1 = 1'b1; cin1 = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("rst_state8", {22'd0, busy8, done8, cout8, sum8}, 0);
        check("rst_state1", {28'd0, busy1, done1, cout1, sum1}, 0);
        @(negedge clk);
        rst_n = 1'b1; start8 = 1'b0; start1 = 1'b0;
        @(posedge clk); #1;
        check("idle_after_rst", {30'd0, busy8, busy1}, 0);

        run8(8'h00, 8'h00, 1'b0, 0);
        run8(8'hFF, 8'h01, 1'b0, 0);
        run8(8'hA5, 8'h5A, 1'b1, 1);
        run8(8'h0F, 8'h01, 1'b0, 2);

        // Reset in RUN cycle 4 with start held high
        @(negedge clk);
        start8 = 1'b1; a8 = 8'h3C; b8 = 8'h42; cin8 = 1'b0;
        @(posedge clk); #1;
        start8 = 1'b0;
        repeat (3) begin @(posedge clk); #1; end
        check("mid_run_busy", {31'd0, busy8}, 1);
        rst_n = 1'b0; start8 = 1'b1;
        @(posedge clk); #1;
        check("mid_rst_state", {22'd0, busy8, done8, cout8, sum8}, 0);
        rst_n = 1'b1; start8 = 1'b0;
        @(posedge clk); #1;
        check("post_rst_idle", {30'd0, busy8, done8}, 0);
        run8(8'h03, 8'h04, 1'b0, 0);

        repeat (20) begin
            run8(8'($urandom), 8'($urandom), 1'($urandom), int'($urandom_range(0, 3)));
        end

        for (int i = 0; i < 8; i++) begin
            logic [2:0] v;
            v = 3'(i);
            run1(v[2], v[1], v[0]);
        end

        $display("%0d/%0d checks passed", checks - fails, checks);
        $finish;
    end

endmodule
`default_nettype wire
